muldiv_unit: RTL and testbench

Parametrised iterative multiply/divide unit that replaces the separate fixed-width mult and div blocks feeding the Hi/Lo registers of the multicycle datapath. Supports signed and unsigned multiply and divide on WIDTH-bit operands with a start/busy/done handshake the control unit can sequence. Results appear on hi/lo and are held until the next accepted operation. Divide-by-zero is flagged rather than computed.

---
 rtl/muldiv_unit.sv | 139 +++++++++++++
 tb/tb_muldiv_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply and divide feeding the Hi/Lo registers.
// One shift-add or restoring shift-subtract step per cycle on operand
// magnitudes, followed by a single sign-fix cycle that loads hi/lo.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int unsigned W2    = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [W2-1:0]    acc;      // mult: {partial product, multiplier}; div: {remainder, quotient}
    logic [WIDTH-1:0] opnd;     // multiplicand or divisor magnitude
    logic             is_div;
    logic             neg_q;    // product / quotient needs negation
    logic             neg_r;    // remainder needs negation (dividend sign)

    logic             op_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_trial;
    logic [WIDTH:0]   div_diff;
    logic [W2-1:0]    prod_fix;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    // Operand magnitudes, one iteration step and the final sign correction
    always_comb begin
        op_signed = ~op[0];
        a_neg     = op_signed & a[WIDTH-1];
        b_neg     = op_signed & b[WIDTH-1];
        a_mag     = a_neg ? (~a + WIDTH'(1)) : a;
        b_mag     = b_neg ? (~b + WIDTH'(1)) : b;

        mul_sum   = {1'b0, acc[W2-1:WIDTH]} + {1'b0, {WIDTH{acc[0]}} & opnd};

        div_trial = acc[W2-1:WIDTH-1];
        div_diff  = div_trial - {1'b0, opnd};

        prod_fix  = neg_q ? (~acc + W2'(1)) : acc;
        quo_fix   = neg_q ? (~acc[WIDTH-1:0] + WIDTH'(1)) : acc[WIDTH-1:0];
        rem_fix   = neg_r ? (~acc[W2-1:WIDTH] + WIDTH'(1)) : acc[W2-1:WIDTH];
    end

    // Control FSM with datapath registers and registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            acc      <= '0;
            opnd     <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        div_zero <= 1'b0;
                        if (op[1] && (b == '0)) begin
                            // divide by zero completes at once, hi/lo untouched
                            done     <= 1'b1;
                            div_zero <= 1'b1;
                        end else begin
                            is_div <= op[1];
                            neg_q  <= a_neg ^ b_neg;
                            neg_r  <= a_neg;
                            opnd   <= b_mag;
                            acc    <= {{WIDTH{1'b0}}, a_mag};
                            cnt    <= '0;
                            busy   <= 1'b1;
                            state  <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (is_div) begin
                        if (div_diff[WIDTH]) begin
                            acc <= {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
                        end else begin
                            acc <= {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                        end
                    end else begin
                        acc <= {mul_sum, acc[WIDTH-1:1]};
                    end
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST_ITER) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (is_div) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        hi <= prod_fix[W2-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: WIDTH=32 and WIDTH=8 instances, directed vector
// table, random vectors against a behavioural model, reset and busy corners.
module tb_muldiv_unit;

    localparam logic [1:0] OP_MULT  = 2'd0;
    localparam logic [1:0] OP_MULTU = 2'd1;
    localparam logic [1:0] OP_DIV   = 2'd2;
    localparam logic [1:0] OP_DIVU  = 2'd3;

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    typedef struct packed {
        logic [63:0] hi;
        logic [63:0] lo;
        logic        dz;
        logic [7:0]  lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    logic        start32, start8;
    logic [1:0]  op32, op8;
    logic [31:0] a32, b32, hi32, lo32;
    logic [7:0]  a8, b8, hi8, lo8;
    logic        busy32, done32, dz32, busy8, done8, dz8;

    logic        sel8;
    logic [63:0] hi_s, lo_s;
    logic        busy_s, done_s, dz_s;

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;
    exp_t        sb_q[$];
    vec_t        tbl[15];

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .start(start32), .op(op32), .a(a32), .b(b32),
        .hi(hi32), .lo(lo32), .busy(busy32), .done(done32), .div_zero(dz32)
    );

    muldiv_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
        .hi(hi8), .lo(lo8), .busy(busy8), .done(done8), .div_zero(dz8)
    );

    assign hi_s   = sel8 ? 64'(hi8) : 64'(hi32);
    assign lo_s   = sel8 ? 64'(lo8) : 64'(lo32);
    assign busy_s = sel8 ? busy8 : busy32;
    assign done_s = sel8 ? done8 : done32;
    assign dz_s   = sel8 ? dz8 : dz32;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit w8, input logic s, input logic [1:0] o,
                         input logic [63:0] av, input logic [63:0] bv);
        if (w8) begin
            start8 = s; op8 = o; a8 = av[7:0]; b8 = bv[7:0];
        end else begin
            start32 = s; op32 = o; a32 = av[31:0]; b32 = bv[31:0];
        end
    endtask

    // Behavioural reference, valid for widths up to 32
    function automatic void model(input int unsigned w, input logic [1:0] o,
                                  input logic [63:0] av, input logic [63:0] bv,
                                  output logic [63:0] ehi, output logic [63:0] elo);
        logic [63:0] mask, ua, ub, p;
        longint sa, sb, q, r;
        mask = (64'd1 << w) - 64'd1;
        ua = av & mask;
        ub = bv & mask;
        sa = ua[w-1] ? longint'(ua) - longint'(64'd1 << w) : longint'(ua);
        sb = ub[w-1] ? longint'(ub) - longint'(64'd1 << w) : longint'(ub);
        case (o)
            OP_MULT:  begin p = 64'(sa * sb); ehi = (p >> w) & mask; elo = p & mask; end
            OP_MULTU: begin p = ua * ub;      ehi = (p >> w) & mask; elo = p & mask; end
            OP_DIV:   begin q = sa / sb; r = sa % sb; ehi = 64'(r) & mask; elo = 64'(q) & mask; end
            default:  begin ehi = (ua % ub) & mask; elo = (ua / ub) & mask; end
        endcase
    endfunction

    // Issue one operation, then wait for done and score it against the queue
    task automatic issue(input bit w8, input string tag, input logic [1:0] o,
                         input logic [63:0] av, input logic [63:0] bv,
                         input logic [63:0] ehi, input logic [63:0] elo,
                         input logic edz, input bit junk);
        exp_t e;
        exp_t g;
        int unsigned cyc;
        int unsigned busy_bad;
        sel8  = w8;
        e.hi  = ehi;
        e.lo  = elo;
        e.dz  = edz;
        e.lat = edz ? 8'd0 : (w8 ? 8'd9 : 8'd33);
        sb_q.push_back(e);
        drive(w8, 1'b1, o, av, bv);
        @(posedge clk); #1;
        drive(w8, 1'b0, o, av, bv);
        if (edz) chk($sformatf("%s busy_dz", tag), 64'(busy_s), 64'd0);
        cyc = 0;
        busy_bad = 0;
        while (done_s !== 1'b1 && cyc < 200) begin
            if (busy_s !== 1'b1) busy_bad++;
            if (junk && (cyc == 3 || cyc == 4 || cyc == 20))
                drive(w8, 1'b1, ~o, ~av, 64'd0);
            else
                drive(w8, 1'b0, o, av, bv);
            @(posedge clk); #1;
            cyc++;
        end
        drive(w8, 1'b0, o, av, bv);
        g = sb_q.pop_front();
        chk($sformatf("%s latency", tag), 64'(cyc), 64'(g.lat));
        chk($sformatf("%s busy_low_cycles", tag), 64'(busy_bad), 64'd0);
        chk($sformatf("%s busy_at_done", tag), 64'(busy_s), 64'd0);
        chk($sformatf("%s hi", tag), hi_s, g.hi);
        chk($sformatf("%s lo", tag), lo_s, g.lo);
        chk($sformatf("%s div_zero", tag), 64'(dz_s), 64'(g.dz));
    endtask

    initial begin
        logic [1:0]  ro;
        logic [63:0] ra, rb, ehi, elo;

        tbl[0]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        tbl[1]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        tbl[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        tbl[3]  = '{OP_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0};
        tbl[4]  = '{OP_DIVU,  32'h00000005, 32'h00000000, 32'h00000001, 32'h00000003, 1'b1};
        tbl[5]  = '{OP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0};
        tbl[6]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        tbl[7]  = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        tbl[8]  = '{OP_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 1'b0};
        tbl[9]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        tbl[10] = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0};
        tbl[11] = '{OP_MULT,  32'h00000000, 32'h12345678, 32'h00000000, 32'h00000000, 1'b0};
        tbl[12] = '{OP_DIVU,  32'h00000003, 32'h00000005, 32'h00000003, 32'h00000000, 1'b0};
        tbl[13] = '{OP_MULT,  32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b0};
        tbl[14] = '{OP_DIV,   32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1};

        sel8 = 1'b0;
        reset = 1'b0;
        drive(1'b0, 1'b0, OP_MULT, 64'd0, 64'd0);
        drive(1'b1, 1'b0, OP_MULT, 64'd0, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset hi", hi_s, 64'd0);
        chk("reset lo", lo_s, 64'd0);
        chk("reset busy_done_dz", {61'd0, busy_s, done_s, dz_s}, 64'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Directed table, back to back (each start lands in the done cycle)
        for (int i = 0; i < 15; i++) begin
            issue(1'b0, $sformatf("vec%0d", i), tbl[i].op, 64'(tbl[i].a), 64'(tbl[i].b),
                  64'(tbl[i].hi), 64'(tbl[i].lo), tbl[i].dz, (i == 1));
        end

        // Reset in the middle of a multiply, with start held during reset
        sel8 = 1'b0;
        drive(1'b0, 1'b1, OP_MULT, 64'd5, 64'd6);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, OP_MULT, 64'd5, 64'd6);
        repeat (9) begin @(posedge clk); #1; end
        chk("midop busy", 64'(busy_s), 64'd1);
        reset = 1'b0;
        drive(1'b0, 1'b1, OP_DIVU, 64'd7, 64'd0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, OP_DIVU, 64'd7, 64'd0);
        chk("abort busy_done_dz", {61'd0, busy_s, done_s, dz_s}, 64'd0);
        chk("abort hi", hi_s, 64'd0);
        chk("abort lo", lo_s, 64'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        issue(1'b0, "post_reset", OP_MULT, 64'd5, 64'd6, 64'd0, 64'd30, 1'b0, 1'b0);

        // Random WIDTH=32 vectors against the model
        for (int i = 0; i < 16; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = 64'($urandom);
            rb = 64'($urandom);
            if (i % 5 == 0) ra = 64'h80000000;
            if (rb == 64'd0) rb = 64'd1;
            model(32, ro, ra, rb, ehi, elo);
            issue(1'b0, $sformatf("rnd32_%0d", i), ro, ra, rb, ehi, elo, 1'b0, 1'b0);
        end

        // WIDTH=8 corners and random vectors
        issue(1'b1, "w8_div_ovf", OP_DIV, 64'h80, 64'hFF, 64'h00, 64'h80, 1'b0, 1'b0);
        issue(1'b1, "w8_mult_min", OP_MULT, 64'h80, 64'h80, 64'h40, 64'h00, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = 64'($urandom_range(0, 255));
            rb = 64'($urandom_range(1, 255));
            model(8, ro, ra, rb, ehi, elo);
            issue(1'b1, $sformatf("rnd8_%0d", i), ro, ra, rb, ehi, elo, 1'b0, 1'b0);
        end

        // done must be a single-cycle pulse
        @(posedge clk); #1;
        chk("done_pulse_width", 64'(done_s), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
